// File: rtl/tl_assert_report_arbiter_pkg.sv
// Shared types and defaults for the assertion-report arbiter.
// Holds the FSM state encoding, default sizes and the index-width helper.
package tl_assert_pkg;

  localparam int DEF_N_SRC = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPORT = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Width of a source index; at least one bit even for degenerate counts.
  function automatic int id_w(input int n);
    if (n < 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/tl_assert_report_arbiter_if.sv
// Report channel between the arbiter (master) and the reporting sink (slave).
// Valid/ready handshake carrying the source index and report sequence number.
interface tl_assert_report_arbiter_if
  import tl_assert_pkg::*;
#(
  parameter int ID_W  = id_w(DEF_N_SRC),
  parameter int CNT_W = DEF_CNT_W
);

  logic             rpt_valid;
  logic             rpt_ready;
  logic [ID_W-1:0]  rpt_src;
  logic [CNT_W-1:0] rpt_seq;

  modport master (
    output rpt_valid,
    output rpt_src,
    output rpt_seq,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_src,
    input  rpt_seq,
    output rpt_ready
  );

endinterface

// File: rtl/tl_assert_report_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requesting index strictly after
// 'last', wrapping modulo N_SRC, found on a doubled request vector.
module rr_pick
  import tl_assert_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int ID_W  = id_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  logic [2*N_SRC-1:0] req2_s;
  logic [2*N_SRC-1:0] cand_s;
  logic               found_s;

  // Window [last+1, last+N_SRC] of the doubled vector covers every source once.
  always_comb begin
    req2_s  = {req, req};
    cand_s  = '0;
    found_s = 1'b0;
    idx     = '0;
    for (int j = 0; j < 2 * N_SRC; j++) begin
      cand_s[j] = req2_s[j] & (j > int'(last)) & (j <= int'(last) + N_SRC);
    end
    for (int j = 0; j < 2 * N_SRC; j++) begin
      if (cand_s[j] && !found_s) begin
        found_s = 1'b1;
        if (j >= N_SRC) begin
          idx = ID_W'(j - N_SRC);
        end else begin
          idx = ID_W'(j);
        end
      end else begin
        found_s = found_s;
      end
    end
    any = |cand_s;
  end

endmodule

// File: rtl/tl_assert_report_arbiter.sv
// Serializes assertion-monitor violation pulses onto one report channel with
// round-robin grant, first-failure capture, saturating count and sticky halt.
module tl_assert_report_arbiter
  import tl_assert_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int ID_W  = id_w(N_SRC),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_SRC-1:0]           src_fail,
  input  logic [N_SRC-1:0]           src_mask,
  input  logic [CNT_W-1:0]           stop_after,
  tl_assert_report_arbiter_if.master rpt,
  output logic                       first_valid,
  output logic [ID_W-1:0]            first_src,
  output logic [CNT_W-1:0]           fail_count,
  output logic                       halt
);

  localparam int PC_W  = ID_W + 1;
  localparam int SUM_W = CNT_W + PC_W;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic [ID_W-1:0]  rpt_src_q, rpt_src_d;
  logic [CNT_W-1:0] rpt_seq_q, rpt_seq_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic             first_valid_q, first_valid_d;
  logic [ID_W-1:0]  first_src_q, first_src_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic             halt_q, halt_d;

  logic [N_SRC-1:0] acc_s;
  logic [N_SRC-1:0] clr_s;
  logic             hs_s;
  logic [CNT_W-1:0] seq_inc_s;
  logic             pick_any_s;
  logic [ID_W-1:0]  pick_idx_s;
  logic [PC_W-1:0]  popcnt_s;
  logic [SUM_W-1:0] sum_s;
  logic [ID_W-1:0]  low_acc_s;

  rr_pick #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req  (pending_q),
    .last (last_grant_q),
    .any  (pick_any_s),
    .idx  (pick_idx_s)
  );

  // Accepted pulses and pending bits; a new pulse beats a same-cycle clear.
  always_comb begin
    acc_s     = src_fail & ~src_mask & {N_SRC{enable}};
    hs_s      = rpt_valid_q & rpt.rpt_ready;
    seq_inc_s = rpt_seq_q + {{(CNT_W-1){1'b0}}, 1'b1};
    clr_s     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr_s[i] = hs_s & (rpt_src_q == ID_W'(i));
    end
    pending_d = (pending_q & ~clr_s) | acc_s;
  end

  always_comb begin
    popcnt_s  = '0;
    low_acc_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      popcnt_s = popcnt_s + {{(PC_W-1){1'b0}}, acc_s[i]};
    end
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (acc_s[i]) begin
        low_acc_s = ID_W'(i);
      end else begin
        low_acc_s = low_acc_s;
      end
    end
    sum_s = {{PC_W{1'b0}}, fail_count_q} + {{CNT_W{1'b0}}, popcnt_s};
    if (sum_s[SUM_W-1:CNT_W] != '0) begin
      fail_count_d = '1;
    end else begin
      fail_count_d = sum_s[CNT_W-1:0];
    end
    if (!first_valid_q && (acc_s != '0)) begin
      first_valid_d = 1'b1;
      first_src_d   = low_acc_s;
    end else begin
      first_valid_d = first_valid_q;
      first_src_d   = first_src_q;
    end
  end

  // Next-state logic; HALTED is left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = REPORT;
        end else begin
          state_d = IDLE;
        end
      end
      REPORT: begin
        if (hs_s) begin
          if ((stop_after != '0) && (seq_inc_s == stop_after)) begin
            state_d = HALTED;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = REPORT;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output/datapath values registered alongside the state.
  always_comb begin
    rpt_valid_d = (state_d == REPORT);
    halt_d      = (state_d == HALTED);
    if ((state_q == IDLE) && pick_any_s) begin
      rpt_src_d = pick_idx_s;
    end else begin
      rpt_src_d = rpt_src_q;
    end
    if (hs_s) begin
      rpt_seq_d    = seq_inc_s;
      last_grant_d = rpt_src_q;
    end else begin
      rpt_seq_d    = rpt_seq_q;
      last_grant_d = last_grant_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // last_grant resets to the top index so source 0 is served first.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q     <= '0;
      rpt_valid_q   <= 1'b0;
      rpt_src_q     <= '0;
      rpt_seq_q     <= '0;
      last_grant_q  <= ID_W'(N_SRC - 1);
      first_valid_q <= 1'b0;
      first_src_q   <= '0;
      fail_count_q  <= '0;
      halt_q        <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      rpt_valid_q   <= rpt_valid_d;
      rpt_src_q     <= rpt_src_d;
      rpt_seq_q     <= rpt_seq_d;
      last_grant_q  <= last_grant_d;
      first_valid_q <= first_valid_d;
      first_src_q   <= first_src_d;
      fail_count_q  <= fail_count_d;
      halt_q        <= halt_d;
    end
  end

  assign rpt.rpt_valid = rpt_valid_q;
  assign rpt.rpt_src   = rpt_src_q;
  assign rpt.rpt_seq   = rpt_seq_q;
  assign first_valid   = first_valid_q;
  assign first_src     = first_src_q;
  assign fail_count    = fail_count_q;
  assign halt          = halt_q;

endmodule

// File: tb/tb_tl_assert_report_arbiter.sv
// Scoreboard bench: stimulus queues expected reports, a negedge monitor pops
// and compares on each handshake; a 4-bit-counter instance covers wrap/saturation.
module tb_tl_assert_report_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  src_fail;
  logic [7:0]  src_mask;
  logic [15:0] stop_after;
  logic        first_valid;
  logic [2:0]  first_src;
  logic [15:0] fail_count;
  logic        halt;

  logic        enable2;
  logic [7:0]  src_fail2;
  logic [7:0]  src_mask2;
  logic [3:0]  stop_after2;
  logic        first_valid2;
  logic [2:0]  first_src2;
  logic [3:0]  fail_count2;
  logic        halt2;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  tl_assert_report_arbiter_if #(.ID_W(3), .CNT_W(16)) rpt_if ();
  tl_assert_report_arbiter_if #(.ID_W(3), .CNT_W(4))  rpt_if2 ();

  tl_assert_report_arbiter #(.N_SRC(8), .ID_W(3), .CNT_W(16)) dut (
    .clock       (clk),
    .reset       (rst),
    .enable      (enable),
    .src_fail    (src_fail),
    .src_mask    (src_mask),
    .stop_after  (stop_after),
    .rpt         (rpt_if),
    .first_valid (first_valid),
    .first_src   (first_src),
    .fail_count  (fail_count),
    .halt        (halt)
  );

  tl_assert_report_arbiter #(.N_SRC(8), .ID_W(3), .CNT_W(4)) dut2 (
    .clock       (clk),
    .reset       (rst),
    .enable      (enable2),
    .src_fail    (src_fail2),
    .src_mask    (src_mask2),
    .stop_after  (stop_after2),
    .rpt         (rpt_if2),
    .first_valid (first_valid2),
    .first_src   (first_src2),
    .fail_count  (fail_count2),
    .halt        (halt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [7:0] v);
    src_fail = v;
    step(1);
    src_fail = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_rpt_valid",   32'(rpt_if.rpt_valid), 32'd0);
    chk("rst_rpt_src",     32'(rpt_if.rpt_src),   32'd0);
    chk("rst_rpt_seq",     32'(rpt_if.rpt_seq),   32'd0);
    chk("rst_first_valid", 32'(first_valid),      32'd0);
    chk("rst_first_src",   32'(first_src),        32'd0);
    chk("rst_fail_count",  32'(fail_count),       32'd0);
    chk("rst_halt",        32'(halt),             32'd0);
  endtask

  // Monitor: handshake scoreboard plus hold-stability under backpressure.
  logic        prev_hold = 1'b0;
  logic        prev_rst  = 1'b0;
  logic [2:0]  prev_src  = 3'd0;
  logic [15:0] prev_seq  = 16'd0;
  always @(negedge clk) begin
    logic [18:0] e;
    if (prev_hold && !prev_rst) begin
      chk("hold_valid", 32'(rpt_if.rpt_valid), 32'd1);
      chk("hold_src",   32'(rpt_if.rpt_src),   32'(prev_src));
      chk("hold_seq",   32'(rpt_if.rpt_seq),   32'(prev_seq));
    end
    if (rpt_if.rpt_valid && rpt_if.rpt_ready && !rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_report src=%0d seq=%0d required=none",
                 rpt_if.rpt_src, rpt_if.rpt_seq);
      end else begin
        e = exp_q.pop_front();
        chk("rpt_src", 32'(rpt_if.rpt_src), 32'(e[18:16]));
        chk("rpt_seq", 32'(rpt_if.rpt_seq), 32'(e[15:0]));
      end
    end
    prev_hold = rpt_if.rpt_valid && !rpt_if.rpt_ready;
    prev_src  = rpt_if.rpt_src;
    prev_seq  = rpt_if.rpt_seq;
    prev_rst  = rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrep;
    int guard;
    rst = 1'b1;
    enable = 1'b1;
    src_fail = 8'h00;
    src_mask = 8'h00;
    stop_after = 16'd0;
    rpt_if.rpt_ready = 1'b1;
    enable2 = 1'b1;
    src_fail2 = 8'h00;
    src_mask2 = 8'h00;
    stop_after2 = 4'd0;
    rpt_if2.rpt_ready = 1'b0;
    step(2);
    check_reset_state();
    rst = 1'b0;

    // Single source
    exp_q.push_back({3'd2, 16'd0});
    pulse(8'h04);
    step(4);
    chk("single_fail_count",  32'(fail_count),  32'd1);
    chk("single_first_valid", 32'(first_valid), 32'd1);
    chk("single_first_src",   32'(first_src),   32'd2);

    // Simultaneous pulses, round-robin order 0,4,7
    do_reset();
    exp_q.push_back({3'd0, 16'd0});
    exp_q.push_back({3'd4, 16'd1});
    exp_q.push_back({3'd7, 16'd2});
    pulse(8'h91);
    step(10);
    chk("simul_fail_count", 32'(fail_count), 32'd3);
    chk("simul_first_src",  32'(first_src),  32'd0);

    // Backpressure and merge
    do_reset();
    rpt_if.rpt_ready = 1'b0;
    exp_q.push_back({3'd3, 16'd0});
    for (int i = 0; i < 10; i++) begin
      src_fail = (i % 2 == 0) ? 8'h08 : 8'h00;
      step(1);
    end
    src_fail = 8'h00;
    chk("bp_fail_count", 32'(fail_count),       32'd5);
    chk("bp_rpt_valid",  32'(rpt_if.rpt_valid), 32'd1);
    chk("bp_rpt_src",    32'(rpt_if.rpt_src),   32'd3);
    exp_q.push_back({3'd3, 16'd1});
    rpt_if.rpt_ready = 1'b1;
    src_fail = 8'h08;
    step(1);
    src_fail = 8'h00;
    step(4);
    chk("bp_fail_count2", 32'(fail_count), 32'd6);

    // Halt after two reports
    do_reset();
    stop_after = 16'd2;
    exp_q.push_back({3'd1, 16'd0});
    exp_q.push_back({3'd2, 16'd1});
    pulse(8'h26);
    step(10);
    chk("halt_set",       32'(halt),             32'd1);
    chk("halt_no_valid",  32'(rpt_if.rpt_valid), 32'd0);
    pulse(8'h01);
    step(3);
    chk("halt_fail_count", 32'(fail_count),       32'd4);
    chk("halt_sticky",     32'(halt),             32'd1);
    chk("halt_no_valid2",  32'(rpt_if.rpt_valid), 32'd0);
    chk("halt_first_src",  32'(first_src),        32'd1);
    stop_after = 16'd0;

    // Mask and enable
    do_reset();
    src_mask = 8'h10;
    pulse(8'h10);
    step(3);
    chk("mask_fail_count",  32'(fail_count),       32'd0);
    chk("mask_first_valid", 32'(first_valid),      32'd0);
    chk("mask_no_valid",    32'(rpt_if.rpt_valid), 32'd0);
    src_mask = 8'h00;
    enable = 1'b0;
    pulse(8'h01);
    step(3);
    chk("en_fail_count",  32'(fail_count),       32'd0);
    chk("en_first_valid", 32'(first_valid),      32'd0);
    enable = 1'b1;
    step(3);
    chk("en_no_valid", 32'(rpt_if.rpt_valid), 32'd0);

    // Reset while a report is offered drops it
    rpt_if.rpt_ready = 1'b0;
    pulse(8'h40);
    step(2);
    chk("rr_valid",      32'(rpt_if.rpt_valid), 32'd1);
    chk("rr_src",        32'(rpt_if.rpt_src),   32'd6);
    chk("rr_fail_count", 32'(fail_count),       32'd1);
    rst = 1'b1;
    step(1);
    check_reset_state();
    rst = 1'b0;
    rpt_if.rpt_ready = 1'b1;
    step(4);
    chk("rr_dropped", 32'(rpt_if.rpt_valid), 32'd0);

    // 4-bit counters: saturation then sequence wrap
    do_reset();
    src_fail2 = 8'h01;
    rpt_if2.rpt_ready = 1'b0;
    step(14);
    chk("sat_fail_14", 32'(fail_count2), 32'd14);
    step(6);
    chk("sat_fail_20", 32'(fail_count2), 32'd15);
    rpt_if2.rpt_ready = 1'b1;
    nrep = 0;
    guard = 0;
    while (nrep < 17 && guard < 200) begin
      if (rpt_if2.rpt_valid && rpt_if2.rpt_ready) nrep++;
      step(1);
      guard++;
    end
    rpt_if2.rpt_ready = 1'b0;
    src_fail2 = 8'h00;
    chk("wrap_reports",    32'(nrep),            32'd17);
    chk("wrap_rpt_seq",    32'(rpt_if2.rpt_seq), 32'd1);
    chk("wrap_fail_count", 32'(fail_count2),     32'd15);
    chk("wrap_first",      32'({first_valid2, first_src2}), 32'({1'b1, 3'd0}));
    chk("wrap_no_halt",    32'(halt2),           32'd0);

    step(5);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_assert_report_arbiter.md
# tl_assert_report_arbiter

Collects violation pulses from up to N protocol-assertion monitors and serializes them onto one report channel, granting sources round-robin. Latches the first failing source and keeps a saturating count of accepted violations. Raises a sticky halt after a programmable number of delivered reports. Sits between the per-link assertion monitors and the simulation/debug reporting sink, so that concurrent failures are all reported deterministically rather than lost or interleaved.

## Interface
Parameters:
- `N_SRC`, 8: number of monitor sources (2..32).
- `ID_W`, 3: source-index width, equal to clog2(N_SRC).
- `CNT_W`, 16: width of the counters.

Ports:
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: when low, new violation pulses are ignored. Already-pending reports still drain.
- `src_fail`  in  N_SRC: per-source violation pulse, one bit per cycle.
- `src_mask`  in  N_SRC: a 1 suppresses that source's pulses.
- `stop_after`  in  CNT_W: halt once this many reports have been delivered. A value of 0 means never halt.
- `rpt_valid`  out  1: a report is offered.
- `rpt_ready`  in  1: the sink accepts the report.
- `rpt_src`  out  ID_W: index of the reported source.
- `rpt_seq`  out  CNT_W: sequence number of this report, starting at 0.
- `first_valid`  out  1: a first failure has been captured.
- `first_src`  out  ID_W: index of the first failing source.
- `fail_count`  out  CNT_W: accepted violations, saturating at all-ones.
- `halt`  out  1: sticky stop request.

## Operation
- **Accepted pulse:** `acc[i] = src_fail[i] & ~src_mask[i] & enable`.
- **Pending bits:** `pending[i]` is set by `acc[i]`.
  - It is cleared only when a report for source i completes (`rpt_valid & rpt_ready & rpt_src==i`).
  - If set and clear occur in the same cycle, set wins; a new report for that source follows.
  - Repeat pulses while a source is already pending merge into one report, but each is still counted.
- **Fail count:** `fail_count += popcount(acc)` every cycle, saturating at 2^CNT_W-1.
- **First failure:** on the first cycle with any `acc`, capture `first_src` = lowest set index and set `first_valid`. Both hold until reset.
- **FSM states:** IDLE, REPORT, HALTED.
  - **IDLE:** if any pending bit is set, pick the lowest pending index at or after `last_grant+1`, wrapping modulo N_SRC. Register it into `rpt_src` and go to REPORT.
  - **REPORT:** `rpt_valid=1`; `rpt_src` and `rpt_seq` are stable until the handshake. On handshake: clear `pending[rpt_src]`, set `last_grant=rpt_src`, increment `rpt_seq`.
    - If `stop_after!=0` and the incremented `rpt_seq` equals `stop_after`, go to HALTED.
    - Otherwise go to IDLE.
  - **HALTED:** `halt=1`, `rpt_valid=0`. Only reset exits this state. Pending bits, `fail_count` and first-failure capture keep updating.
- **`rpt_seq` wrap:** wraps modulo 2^CNT_W. The halt compare uses the wrapped value.
- **`stop_after` timing:** sampled at each handshake. Lowering it below the current `rpt_seq` never triggers halt until wrap.

## Timing
- Reset values: `rpt_valid=0`, `rpt_src=0`, `rpt_seq=0`, `first_valid=0`, `first_src=0`, `fail_count=0`, `halt=0`. Pending bits are 0 and `last_grant=N_SRC-1`, so source 0 gets first priority.
- Latency: a pulse at edge t sets `pending` at t+1; `rpt_valid` rises at t+2.
- Throughput: one report per 2 cycles when `rpt_ready` is held high (REPORT→IDLE→REPORT).
- `rpt_valid` never deasserts without a handshake, except on reset.
- `fail_count`, `first_*` and `halt` update one cycle after the causing event.
- Reset asserted in REPORT: `rpt_valid=0` at the next edge and the report is dropped.

## Structure
- Package `tl_assert_pkg`:
  - `state_t` enum {IDLE, REPORT, HALTED};
  - default `N_SRC`, `CNT_W`;
  - a `clog2`-based `ID_W` helper.
- Sub-module `rr_pick`: combinational round-robin priority encoder.
  - Inputs: `req[N_SRC]`, `last[ID_W]`.
  - Outputs: `any`, `idx[ID_W]`.
  - Implemented as a double-width masked find-first.
- The top level holds the pending register, FSM, counters and popcount.

## Test plan
- **Single source:** pulse `src_fail=8'h04` once with `rpt_ready=1` → `rpt_valid` at t+2 with `rpt_src=2`, `rpt_seq=0`; `first_src=2`, `fail_count=1`.
- **Simultaneous pulses:** `src_fail=8'h91` in one cycle, ready held high → reports in order 0, 4, 7 with `rpt_seq` 0, 1, 2; `first_src=0`; `fail_count=3`.
- **Backpressure and merge:** `rpt_ready=0` for 10 cycles while source 3 pulses 5 times → exactly one report of source 3, stable throughout; `fail_count=5`. Pulsing source 3 in the handshake cycle yields a second report.
- **Halt:** `stop_after=2`, pulse sources 1, 2 and 5 → two reports, then `halt=1` and `rpt_valid` stays 0. A later pulse still increments `fail_count`.
- **Mask, enable and reset:** a masked source or `enable=0` gives no pending bit and no count. Reset asserted while in REPORT → all outputs return to reset values at the next edge.
- **Saturation and wrap:** with `CNT_W=4`, 20 accepted pulses → `fail_count=15`. Seventeen reports → `rpt_seq` wraps to 1.
